// File: rtl/uart_core_param_if.sv
// Host/pin bundle for uart_core_param: TX request and payload, serial pins, RX results.
// master = host/pin driver side, slave = the UART core.
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 newd;
    logic [DATA_BITS-1:0] dintx;
    logic                 tx;
    logic                 busytx;
    logic                 donetx;
    logic                 rx;
    logic [DATA_BITS-1:0] doutrx;
    logic                 donerx;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output newd, dintx, rx,
        input  tx, busytx, donetx, doutrx, donerx, parity_err, frame_err
    );

    modport slave (
        input  newd, dintx, rx,
        output tx, busytx, donetx, doutrx, donerx, parity_err, frame_err
    );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART on one clock with oversample tick enables; TX line drops the cycle after newd.
// No backpressure: newd is ignored while busytx; RX results land one cycle after the mid-stop sample.
module uart_core_param #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_core_param_if.slave bus
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam bit               HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               r_tx_state, w_tx_next;
    logic [DIV_W-1:0]     r_tx_div;
    logic [OS_W-1:0]      r_tx_os;
    logic [BIT_W-1:0]     r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 w_tx_tick, w_tx_bit_end, w_tx_accept, w_tx_done;

    assign w_tx_tick    = (r_tx_div == DIV_LAST);
    assign w_tx_bit_end = w_tx_tick && (r_tx_os == OS_LAST);

    always_ff @(posedge clk) begin
        if (!rst) r_tx_state <= S_IDLE;
        else      r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_accept = 1'b0;
        w_tx_done   = 1'b0;
        case (r_tx_state)
            S_IDLE:  if (bus.newd) begin
                         w_tx_next   = S_START;
                         w_tx_accept = 1'b1;
                     end
            S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_bit_end && r_tx_bit == BIT_LAST)
                         w_tx_next = HAS_PAR ? S_PAR : S_STOP;
            S_PAR:   if (w_tx_bit_end) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_bit_end && r_tx_stop == STOP_LAST) begin
                         w_tx_next = S_IDLE;
                         w_tx_done = 1'b1;
                     end
            default: w_tx_next = S_IDLE;
        endcase
    end

    // Divider phase restarts at acceptance so the frame length is an exact multiple of DIV.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_div  <= '0;
            r_tx_os   <= '0;
            r_tx_bit  <= '0;
            r_tx_stop <= 1'b0;
            r_tx_sh   <= '0;
            r_tx_par  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_tx_div <= (w_tx_accept || w_tx_tick) ? '0 : r_tx_div + 1'b1;
            if (w_tx_accept) begin
                r_tx_os   <= '0;
                r_tx_bit  <= '0;
                r_tx_stop <= 1'b0;
                r_tx_sh   <= bus.dintx;
                r_tx_par  <= (^bus.dintx) ^ PAR_ODD;
                r_tx      <= 1'b0;
            end else if (w_tx_tick && r_tx_state != S_IDLE) begin
                r_tx_os <= w_tx_bit_end ? '0 : r_tx_os + 1'b1;
                if (w_tx_bit_end) begin
                    case (r_tx_state)
                        S_START: begin
                            r_tx    <= r_tx_sh[0];
                            r_tx_sh <= r_tx_sh >> 1;
                        end
                        S_DATA: begin
                            if (r_tx_bit == BIT_LAST) begin
                                r_tx <= HAS_PAR ? r_tx_par : 1'b1;
                            end else begin
                                r_tx     <= r_tx_sh[0];
                                r_tx_sh  <= r_tx_sh >> 1;
                                r_tx_bit <= r_tx_bit + 1'b1;
                            end
                        end
                        S_PAR:   r_tx      <= 1'b1;
                        S_STOP:  r_tx_stop <= ~r_tx_stop;
                        default: r_tx      <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign bus.tx     = r_tx;
    assign bus.busytx = (r_tx_state != S_IDLE) && !w_tx_done;
    assign bus.donetx = w_tx_done;

    // ---------------- receiver ----------------
    state_t               r_rx_state, w_rx_next;
    logic                 r_rx_s1, r_rx_s2, r_rx_d;
    logic [DIV_W-1:0]     r_rx_div;
    logic [OS_W-1:0]      r_rx_os;
    logic [BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_sh, r_dout;
    logic                 r_rx_pbit, r_donerx, r_perr, r_ferr;
    logic                 w_rx_tick, w_rx_fall, w_rx_mid, w_rx_samp, w_rx_start;

    assign w_rx_tick = (r_rx_div == DIV_LAST);
    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_mid  = w_rx_tick && (r_rx_os == HALF_LAST);
    assign w_rx_samp = w_rx_tick && (r_rx_os == OS_LAST);

    always_ff @(posedge clk) begin
        if (!rst) r_rx_state <= S_IDLE;
        else      r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_start = 1'b0;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) begin
                         w_rx_next  = S_START;
                         w_rx_start = 1'b1;
                     end
            S_START: if (w_rx_mid) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_samp && r_rx_bit == BIT_LAST)
                         w_rx_next = HAS_PAR ? S_PAR : S_STOP;
            S_PAR:   if (w_rx_samp) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_samp) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    // After the mid-start sample the phase counter restarts, so later samples stay bit-centred.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_d    <= 1'b1;
            r_rx_div  <= '0;
            r_rx_os   <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_pbit <= 1'b0;
            r_dout    <= '0;
            r_donerx  <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_s1  <= bus.rx;
            r_rx_s2  <= r_rx_s1;
            r_rx_d   <= r_rx_s2;
            r_donerx <= 1'b0;
            r_rx_div <= (w_rx_start || w_rx_tick) ? '0 : r_rx_div + 1'b1;
            if (w_rx_start) begin
                r_rx_os  <= '0;
                r_rx_bit <= '0;
            end else if (w_rx_tick && r_rx_state != S_IDLE) begin
                if ((r_rx_state == S_START && r_rx_os == HALF_LAST) || r_rx_os == OS_LAST)
                    r_rx_os <= '0;
                else
                    r_rx_os <= r_rx_os + 1'b1;
                if (w_rx_samp) begin
                    case (r_rx_state)
                        S_DATA: begin
                            r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                        S_PAR:  r_rx_pbit <= r_rx_s2;
                        S_STOP: begin
                            r_dout   <= r_rx_sh;
                            r_perr   <= HAS_PAR && (r_rx_pbit != ((^r_rx_sh) ^ PAR_ODD));
                            r_ferr   <= ~r_rx_s2;
                            r_donerx <= 1'b1;
                        end
                        default: r_donerx <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign bus.doutrx     = r_dout;
    assign bus.donerx     = r_donerx;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core, next generation of the team's fixed 8N1 transmitter/receiver pair. It runs entirely in the system clock domain, using a single-cycle oversample tick enable instead of derived clocks. Data width, parity mode, stop-bit count and oversampling ratio are configurable. The receiver samples mid-bit with false-start rejection and reports parity and framing errors. It sits between a byte-level host interface and the serial pins.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate in baud
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, transmitted stop bits, 1 or 2; RX checks only the first
OVERSAMPLE, 16, ticks per bit period; must be an even number ≥ 4

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous active-low reset
newd  in  1  TX request, sampled while TX is idle
dintx  in  DATA_BITS  TX payload, latched on an accepted newd
tx  out  1  serial output, idles high
busytx  out  1  high while a TX frame is in progress
donetx  out  1  1-cycle pulse at the end of the last stop bit
rx  in  1  serial input, asynchronous
doutrx  out  DATA_BITS  last received payload
donerx  out  1  1-cycle pulse when a frame completes
parity_err  out  1  parity mismatch on the last frame; 0 when PARITY = 0
frame_err  out  1  first stop bit sampled low on the last frame

Behaviour:
- Reset (rst = 0 at a clk edge): tx = 1, busytx = 0, donetx = 0, doutrx = 0, donerx = 0, parity_err = 0, frame_err = 0. The divider, all counters and both FSMs return to IDLE. Reset asserted mid-frame aborts the frame immediately; tx is high on the next cycle.
- Tick generator: DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE), integer division. A free-running counter runs 0..DIV-1, and os_tick is high for one clk when the counter equals DIV-1. One bit period is exactly OVERSAMPLE os_ticks.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on newd = 1, latch dintx, set busytx = 1 and drive tx = 0 on the next cycle, then go to START. The tick-phase counter is cleared at acceptance.
  - START to DATA after OVERSAMPLE ticks.
  - DATA shifts out DATA_BITS bits, LSB first, one bit period each, then goes to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR bit: XOR of the payload for even parity; its inverse for odd parity.
  - STOP drives tx = 1 for STOP_BITS bit periods. In the final cycle, donetx pulses for 1 cycle and busytx falls in that same cycle; the FSM returns to IDLE.
  - newd while busytx = 1 is ignored, with no queuing. newd held high re-triggers: the next frame starts the cycle after donetx.
- RX path: rx passes through a 2-flop synchroniser, giving 2 cycles of latency. Edge detection and sampling use only the synchronised signal.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a synchronised high-to-low transition, clear the tick-phase counter and go to START.
  - START: sample at OVERSAMPLE/2 ticks. If the sample is high, it is a false start: return to IDLE with no outputs changed.
  - DATA: sample each bit OVERSAMPLE ticks after the previous sample, LSB first into a shift register, DATA_BITS samples. Then go to PAR or STOP per the PARITY parameter.
  - PAR: sample one bit and compare it with the parity computed over the received payload.
  - STOP: sample one bit. In the same cycle, update doutrx, parity_err and frame_err (frame_err = ~sample) and pulse donerx; return to IDLE immediately, mid-stop-bit, so the receiver resyncs on the next start edge.
  - donerx pulses even on frames with errors. doutrx and both error flags hold until the next donerx.
- RX and TX are fully independent. Loopback (rx tied to tx) must work for every legal parameter set.
- TX frame length in clk cycles = DIV * OVERSAMPLE * (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS), from the cycle tx first goes low to the donetx cycle inclusive.

Test Plan:
1. Defaults with CLK_FREQ = 1600000, BAUD_RATE = 10000, OVERSAMPLE = 16 (DIV = 10, 160 clk per bit); dintx = 8'hA5, newd pulse -> tx = 0 for 160 clk, then bits 1,0,1,0,0,1,0,1, then 1 for 160 clk. donetx pulses exactly 1600 clk after tx first goes low; busytx is high throughout.
2. Loopback with DATA_BITS = 7, PARITY = 2, STOP_BITS = 2; send 7'h55 then 7'h2A back-to-back with newd held high -> two donerx pulses, doutrx = 7'h55 then 7'h2A, parity_err = 0 and frame_err = 0; the tx parity bit is 0 then 1.
3. RX with PARITY = 1: drive the frame 0x3C with a wrong parity bit (0) -> donerx pulses, doutrx = 8'h3C, parity_err = 1. A following correct frame 0x3C clears parity_err to 0.
4. RX framing error: drive frame 0x81 with the stop bit low -> donerx pulses, doutrx = 8'h81, frame_err = 1. Returning rx high, then a good frame 0x00, gives frame_err = 0.
5. False start: drive rx low for 5 bit-ticks (< OVERSAMPLE/2), then high -> no donerx pulse and doutrx unchanged. A subsequent valid frame 0x5A is received correctly.
6. Reset mid-frame: assert rst = 0 during DATA bit 3 of a TX frame and during an RX frame -> next cycle tx = 1, busytx = 0, and all outputs are at reset values. After rst = 1, a new newd with 8'hFF transmits a full, correct frame.
